// File: rtl/product_bcd_display.sv
// product_bcd_display
//   Captures the 16-bit product from the 8x8 multiplier on done_flag. It
//   converts it to 5-digit BCD with a one-iteration-per-clock double-dabble
//   engine. It scans the last completed result onto a 5-digit common
//   7-segment display, with leading-zero blanking.
//
// Ports
//   clk          system clock, rising edge
//   reset_a      synchronous active-high reset
//   done_flag    one-cycle start pulse; product_in valid while high
//   product_in   unsigned 16-bit product
//   busy         high while a conversion is running
//   bcd_stb      one-cycle pulse when bcd_out updates
//   bcd_out      last completed result, [3:0] = units
//   digit_en     one-hot digit select, bit0 = units
//   seg_a..seg_g active-high segments of the selected digit

// Per-digit double-dabble correction: add 3 to any nibble >= 5 before the
// shift. After the shift the nibble then carries into the next digit correctly.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module product_bcd_display #(
  parameter int SCAN_DIV = 1024
) (
  input  logic        clk,
  input  logic        reset_a,
  input  logic        done_flag,
  input  logic [15:0] product_in,
  output logic        busy,
  output logic        bcd_stb,
  output logic [19:0] bcd_out,
  output logic [4:0]  digit_en,
  output logic        seg_a,
  output logic        seg_b,
  output logic        seg_c,
  output logic        seg_d,
  output logic        seg_e,
  output logic        seg_f,
  output logic        seg_g
);
  localparam int NUM_DIG = 5;
  localparam logic [15:0] PRESC_TC = 16'(SCAN_DIV - 1);

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t      state, state_nxt;
  logic [15:0] bin_sr;
  logic [19:0] bcd_acc;
  logic [3:0]  iter_cnt;

  logic [NUM_DIG-1:0][3:0] acc_nib, adj_nib, out_nib;
  logic [19:0] adj_flat, bcd_nxt;
  logic        start, last;

  assign start = (state == IDLE) && done_flag;
  assign last  = (state == CONVERT) && (iter_cnt == 4'd15);

  // ---------------- conversion engine ----------------
  assign acc_nib = bcd_acc;

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
    bcd_add3 u_add3 (.din(acc_nib[g]), .dout(adj_nib[g]));
  end

  // The corrected accumulator is shifted left, and the binary MSB enters at the bottom.
  assign adj_flat = adj_nib;
  assign bcd_nxt  = {adj_flat[18:0], bin_sr[15]};

  // State register
  always_ff @(posedge clk) begin
    if (reset_a) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (done_flag) state_nxt = CONVERT;
      CONVERT: if (last)      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state == CONVERT);
  end

  // Datapath. bcd_out is written only on the final iteration, so an aborted
  // conversion never leaks a partial value.
  always_ff @(posedge clk) begin
    if (reset_a) begin
      bin_sr   <= '0;
      bcd_acc  <= '0;
      iter_cnt <= '0;
      bcd_out  <= '0;
      bcd_stb  <= 1'b0;
    end else begin
      bcd_stb <= last;
      if (start) begin
        bin_sr   <= product_in;
        bcd_acc  <= '0;
        iter_cnt <= '0;
      end else if (state == CONVERT) begin
        bin_sr   <= {bin_sr[14:0], 1'b0};
        bcd_acc  <= bcd_nxt;
        iter_cnt <= iter_cnt + 4'd1;
        if (last) bcd_out <= bcd_nxt;
      end
    end
  end

  // ---------------- display scan ----------------
  logic [15:0] presc;
  logic [2:0]  dig_idx;

  always_ff @(posedge clk) begin
    if (reset_a) begin
      presc   <= '0;
      dig_idx <= '0;
    end else if (presc == PRESC_TC) begin
      presc   <= '0;
      dig_idx <= (dig_idx == 3'd4) ? 3'd0 : dig_idx + 3'd1;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  assign digit_en = 5'd1 << dig_idx;

  // zero_up[i]: digit i and every digit above it are zero.
  logic [NUM_DIG-1:0] zero_up;
  assign out_nib = bcd_out;
  assign zero_up[NUM_DIG-1] = (out_nib[NUM_DIG-1] == 4'd0);
  for (genvar g = NUM_DIG - 2; g >= 0; g--) begin : g_zero
    assign zero_up[g] = zero_up[g+1] && (out_nib[g] == 4'd0);
  end

  logic [3:0] cur_nib;
  logic       blank;
  logic [6:0] seg;

  assign cur_nib = out_nib[dig_idx];
  assign blank   = (dig_idx != 3'd0) && zero_up[dig_idx];

  always_comb begin
    seg = 7'b0000000;
    if (!blank) begin
      case (cur_nib)
        4'd0: seg = 7'b1111110;
        4'd1: seg = 7'b0110000;
        4'd2: seg = 7'b1101101;
        4'd3: seg = 7'b1111001;
        4'd4: seg = 7'b0110011;
        4'd5: seg = 7'b1011011;
        4'd6: seg = 7'b1011111;
        4'd7: seg = 7'b1110000;
        4'd8: seg = 7'b1111111;
        4'd9: seg = 7'b1111011;
        default: seg = 7'b0000000;
      endcase
    end
  end

  assign {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = seg;
endmodule

// File: tb/tb_product_bcd_display.sv
// Directed bench for product_bcd_display with SCAN_DIV = 4.
module tb_product_bcd_display;
  logic        clk = 1'b0;
  logic        reset_a = 1'b1;
  logic        done_flag = 1'b0;
  logic [15:0] product_in = '0;
  logic        busy, bcd_stb;
  logic [19:0] bcd_out;
  logic [4:0]  digit_en;
  logic        seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
  logic [6:0]  segs;

  int tests = 0;
  int fails = 0;

  product_bcd_display #(.SCAN_DIV(4)) dut (
    .clk(clk), .reset_a(reset_a), .done_flag(done_flag), .product_in(product_in),
    .busy(busy), .bcd_stb(bcd_stb), .bcd_out(bcd_out), .digit_en(digit_en),
    .seg_a(seg_a), .seg_b(seg_b), .seg_c(seg_c), .seg_d(seg_d),
    .seg_e(seg_e), .seg_f(seg_f), .seg_g(seg_g)
  );

  assign segs = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Pulse done_flag for one edge (edge N); returns 1 time unit after edge N.
  task automatic start(input logic [15:0] p);
    product_in = p;
    done_flag  = 1'b1;
    @(posedge clk); #1;
    done_flag  = 1'b0;
  endtask

  // Poll until the given digit is selected (bounded).
  task automatic wait_digit(input int d, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (digit_en === (5'd1 << d)) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    bit ok;
    reset_a = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (bcd_out !== 20'h0) begin fails++; $display("FAIL reset_bcd_out got %h exp 00000", bcd_out); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (bcd_stb !== 1'b0) begin fails++; $display("FAIL reset_stb got %b exp 0", bcd_stb); end
    tests++; if (digit_en !== 5'b00001) begin fails++; $display("FAIL reset_digit_en got %b exp 00001", digit_en); end
    tests++; if (segs !== 7'b1111110) begin fails++; $display("FAIL reset_segs got %b exp 1111110", segs); end
    reset_a = 1'b0;
    for (int d = 1; d < 5; d++) begin
      wait_digit(d, ok);
      tests++; if (!ok) begin fails++; $display("FAIL reset_scan_timeout digit %0d got %b", d, digit_en); end
      tests++; if (segs !== 7'b0000000) begin fails++; $display("FAIL reset_blank digit %0d got %b exp 0000000", d, segs); end
    end
  endtask

  task automatic test_max();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL max_idle_busy got %b exp 0", busy); end
    start(16'hFE01);
    for (int i = 1; i <= 16; i++) begin
      // Sample between edge N+i-1 and N+i.
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL max_busy cyc %0d got %b exp 1", i, busy); end
      tests++; if (bcd_stb !== 1'b0) begin fails++; $display("FAIL max_early_stb cyc %0d got %b exp 0", i, bcd_stb); end
      tests++; if (bcd_out !== 20'h0) begin fails++; $display("FAIL max_early_out cyc %0d got %h exp 00000", i, bcd_out); end
      @(posedge clk); #1;
    end
    tests++; if (bcd_out !== 20'h65025) begin fails++; $display("FAIL max_result got %h exp 65025", bcd_out); end
    tests++; if (bcd_stb !== 1'b1) begin fails++; $display("FAIL max_stb got %b exp 1", bcd_stb); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL max_done_busy got %b exp 0", busy); end
    @(posedge clk); #1;
    tests++; if (bcd_stb !== 1'b0) begin fails++; $display("FAIL max_stb_width got %b exp 0", bcd_stb); end
    tests++; if (bcd_out !== 20'h65025) begin fails++; $display("FAIL max_hold got %h exp 65025", bcd_out); end
  endtask

  task automatic test_blanking();
    bit ok;
    logic [6:0] exp_seg [5] = '{7'b1111110, 7'b1111110, 7'b0110000, 7'b0000000, 7'b0000000};
    start(16'h0064);
    repeat (16) @(posedge clk);
    #1;
    tests++; if (bcd_out !== 20'h00100) begin fails++; $display("FAIL blank_result got %h exp 00100", bcd_out); end
    for (int d = 0; d < 5; d++) begin
      wait_digit(d, ok);
      tests++; if (!ok) begin fails++; $display("FAIL blank_scan_timeout digit %0d got %b", d, digit_en); end
      tests++; if (segs !== exp_seg[d]) begin fails++; $display("FAIL blank_seg digit %0d got %b exp %b", d, segs, exp_seg[d]); end
    end
  endtask

  task automatic test_ignored_start();
    int stb_cnt = 0;
    int busy_cnt = 0;
    start(16'h0007);
    repeat (4) @(posedge clk);
    #1;
    product_in = 16'h1234;
    done_flag  = 1'b1;           // sampled at edge N+5
    @(posedge clk); #1;
    done_flag  = 1'b0;
    for (int k = 6; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bcd_stb) stb_cnt++;
      if (busy) busy_cnt++;
    end
    tests++; if (bcd_out !== 20'h00007) begin fails++; $display("FAIL ign_result got %h exp 00007", bcd_out); end
    tests++; if (stb_cnt !== 1) begin fails++; $display("FAIL ign_stb_count got %0d exp 1", stb_cnt); end
    tests++; if (busy_cnt !== 10) begin fails++; $display("FAIL ign_busy_cycles got %0d exp 10", busy_cnt); end
  endtask

  task automatic test_back_to_back();
    start(16'd9999);
    repeat (15) @(posedge clk);
    #1;
    product_in = 16'd1;          // sampled at completion edge N+16: ignored
    done_flag  = 1'b1;
    @(posedge clk); #1;
    tests++; if (bcd_out !== 20'h09999) begin fails++; $display("FAIL b2b_first got %h exp 09999", bcd_out); end
    tests++; if (bcd_stb !== 1'b1) begin fails++; $display("FAIL b2b_first_stb got %b exp 1", bcd_stb); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle got %b exp 0", busy); end
    product_in = 16'd4321;       // sampled at N+17: accepted
    @(posedge clk); #1;
    done_flag  = 1'b0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_restart got %b exp 1", busy); end
    repeat (16) @(posedge clk);
    #1;
    tests++; if (bcd_out !== 20'h04321) begin fails++; $display("FAIL b2b_second got %h exp 04321", bcd_out); end
    tests++; if (bcd_stb !== 1'b1) begin fails++; $display("FAIL b2b_second_stb got %b exp 1", bcd_stb); end
  endtask

  task automatic test_scan();
    bit ok;
    logic [4:0] exp_en;
    wait_digit(4, ok);
    tests++; if (!ok) begin fails++; $display("FAIL scan_sync4 got %b", digit_en); end
    wait_digit(0, ok);
    tests++; if (!ok) begin fails++; $display("FAIL scan_sync0 got %b", digit_en); end
    for (int i = 0; i < 24; i++) begin
      exp_en = 5'd1 << ((i / 4) % 5);
      tests++; if (digit_en !== exp_en) begin fails++; $display("FAIL scan_step %0d got %b exp %b", i, digit_en, exp_en); end
      if (i == 10) begin
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL scan_inflight got %b exp 1", busy); end
      end
      if (i == 1) begin product_in = 16'h00FF; done_flag = 1'b1; end
      if (i == 2) done_flag = 1'b0;
      @(posedge clk); #1;
    end
    tests++; if (bcd_out !== 20'h00255) begin fails++; $display("FAIL scan_result got %h exp 00255", bcd_out); end
  endtask

  task automatic test_reset_mid();
    int stb_cnt = 0;
    int busy_cnt = 0;
    start(16'h3039);
    repeat (7) @(posedge clk);
    #1;
    reset_a = 1'b1;              // sampled at edge N+8
    @(posedge clk); #1;
    reset_a = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy got %b exp 0", busy); end
    tests++; if (bcd_out !== 20'h0) begin fails++; $display("FAIL rmid_out got %h exp 00000", bcd_out); end
    tests++; if (bcd_stb !== 1'b0) begin fails++; $display("FAIL rmid_stb got %b exp 0", bcd_stb); end
    tests++; if (digit_en !== 5'b00001) begin fails++; $display("FAIL rmid_digit_en got %b exp 00001", digit_en); end
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bcd_stb) stb_cnt++;
      if (busy) busy_cnt++;
    end
    tests++; if (stb_cnt !== 0) begin fails++; $display("FAIL rmid_no_stb got %0d exp 0", stb_cnt); end
    tests++; if (busy_cnt !== 0) begin fails++; $display("FAIL rmid_no_busy got %0d exp 0", busy_cnt); end
    tests++; if (bcd_out !== 20'h0) begin fails++; $display("FAIL rmid_out_hold got %h exp 00000", bcd_out); end
    start(16'h3039);
    repeat (16) @(posedge clk);
    #1;
    tests++; if (bcd_out !== 20'h12345) begin fails++; $display("FAIL rmid_rerun got %h exp 12345", bcd_out); end
    tests++; if (bcd_stb !== 1'b1) begin fails++; $display("FAIL rmid_rerun_stb got %b exp 1", bcd_stb); end
  endtask

  initial begin
    test_reset();
    test_max();
    test_blanking();
    test_ignored_start();
    test_back_to_back();
    test_scan();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/product_bcd_display.md
Name: product_bcd_display

Overview:
Downstream consumer of the 8x8 sequential multiplier. It captures the 16-bit product when the multiplier signals done. It converts the product to 5-digit BCD with a sequential shift-add-3 (double-dabble) engine. It then time-multiplexes the result onto a 5-digit common 7-segment display, alongside the multiplier's state display.

Parameters:
SCAN_DIV, 1024, clocks per digit slot in the display scan; legal range 2..65535.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset_a  input  1  synchronous, active-high reset
done_flag  input  1  one-cycle pulse from multiplier; product_in valid while high
product_in  input  16  unsigned multiplier result (product8x8_out)
busy  output  1  high while a conversion is in progress
bcd_stb  output  1  one-cycle pulse when bcd_out is updated
bcd_out  output  20  last completed result, 5 BCD nibbles; [3:0] = units, [19:16] = ten-thousands
digit_en  output  5  one-hot active-high digit select; bit0 = units
seg_a..seg_g  output  1 each  active-high segments of the currently selected digit

Behaviour:
- Reset (reset_a high at a clock edge) applies to every register:
  - state = IDLE, busy = 0, bcd_stb = 0, bcd_out = 0.
  - Scan prescaler = 0, digit index = 0, so digit_en = 5'b00001.
  - Segments show "0": {a..g} = 1111110.
- Reset mid-conversion aborts the conversion. bcd_out stays 0 (no partial result is ever visible).
- FSM states are IDLE and CONVERT.
- IDLE:
  - done_flag = 1 at edge N latches product_in into a 16-bit shift register and clears a 20-bit BCD accumulator and the 4-bit iteration counter.
  - The state moves to CONVERT and busy = 1 from edge N.
- CONVERT, one iteration per clock on edges N+1..N+16:
  - Each BCD nibble >= 5 has 3 added to it.
  - Then {bcd_acc, bin_sr} shifts left by 1.
  - At edge N+16 (counter terminal value 15):
    - bcd_out <= final accumulator; bcd_stb = 1 for exactly the cycle after N+16.
    - busy = 0; state returns to IDLE.
  - Total capture-to-result latency is 16 clocks.
- done_flag asserted while in CONVERT (including the completion edge) is ignored and not queued. A pulse in the cycle after completion is accepted normally.
- bcd_out changes only at conversion completion. The display keeps showing the previous result during a conversion.
- Arithmetic: the maximum input is 65535, so 5 digits suffice and no overflow case exists. Nibbles are never > 9 at completion.
- Scan:
  - Free-running prescaler counts 0..SCAN_DIV-1 independent of the FSM.
  - On the terminal count the digit index advances 0->1->2->3->4->0 and the prescaler wraps to 0.
  - digit_en is the one-hot decode of the index.
- Segment output is combinational from the digit index and bcd_out. Encoding {a..g}:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - Any other code = 0000000.
- Leading-zero blanking:
  - A digit above the most significant nonzero digit outputs 0000000 while still enabled.
  - The units digit is never blanked.
  - Zeros below the MS nonzero digit are shown.

Test Plan:
- Reset: assert reset_a 2 cycles -> bcd_out=0, busy=0, bcd_stb=0, digit_en=00001, segs=1111110; the zero is shown only on digit 0, digits 1-4 are blanked.
- Max product: product_in=16'hFE01, done_flag 1 cycle -> busy high 16 cycles, bcd_out=20'h65025 after edge N+16, bcd_stb high exactly 1 cycle.
- Blanking: product_in=16'h0064 -> bcd_out=20'h00100. Digits 0,1 show 1111110, digit 2 shows 0110000, digits 3,4 show 0000000.
- Ignored start: product_in=16'h0007 then a second done_flag with 16'h1234 at cycle N+5 -> result 20'h00007, a single bcd_stb, no second conversion.
- Scan (SCAN_DIV=4): digit_en steps 00001->00010->00100->01000->10000->00001, each held 4 clocks, unaffected by an in-flight conversion.
- Reset mid-conversion: done_flag with 16'h3039, reset_a at N+8 -> busy=0, bcd_out=0, no bcd_stb. A following done_flag with 16'h3039 yields 20'h12345.
